// File: rtl/esm_issue_buffer_if.sv
// Bundle of fetch, core-load, core-select and downstream-issue signals for esm_issue_buffer.
// stall_cnt is present only when ESM_ISSUE_STALL_CNT_EN is defined.
interface esm_issue_buffer_if #(
   parameter int unsigned Instruction_word_size = 32,
   parameter int unsigned bs                    = 16
);
   localparam int unsigned IdxW = $clog2(bs);

   logic                             in_valid;
   logic [Instruction_word_size-1:0] in_instr;
   logic                             in_regwrite;
   logic                             in_alusrc;
   logic                             in_ready;
   logic [Instruction_word_size-1:0] Instr_out;
   logic                             RegWrite_out;
   logic                             ALUSrc_out;
   logic [IdxW-1:0]                  buffer_index_out;
   logic [0:bs-1]                    valid_entries_out;
   logic                             proceed_out;
   logic [IdxW-1:0]                  sel_index;
   logic                             sel_valid;
   logic                             issue_valid;
   logic [Instruction_word_size-1:0] issue_instr;
   logic                             issue_ready;
   logic [IdxW:0]                    occupancy;
`ifdef ESM_ISSUE_STALL_CNT_EN
   logic [15:0]                      stall_cnt;
`endif

   // slave: the issue buffer itself; master: fetch, core and downstream side.
   modport slave (
      input  in_valid, in_instr, in_regwrite, in_alusrc, sel_index, sel_valid, issue_ready,
`ifdef ESM_ISSUE_STALL_CNT_EN
      output stall_cnt,
`endif
      output in_ready, Instr_out, RegWrite_out, ALUSrc_out, buffer_index_out,
      output valid_entries_out, proceed_out, issue_valid, issue_instr, occupancy
   );

   modport master (
      output in_valid, in_instr, in_regwrite, in_alusrc, sel_index, sel_valid, issue_ready,
`ifdef ESM_ISSUE_STALL_CNT_EN
      input  stall_cnt,
`endif
      input  in_ready, Instr_out, RegWrite_out, ALUSrc_out, buffer_index_out,
      input  valid_entries_out, proceed_out, issue_valid, issue_instr, occupancy
   );
endinterface

// File: rtl/esm_issue_buffer.sv
// Slot buffer feeding the ESM core and issuing its selected instruction downstream.
// Optional macro ESM_ISSUE_STALL_CNT_EN adds a saturating stall_cnt output.
module esm_issue_buffer #(
   parameter int unsigned Instruction_word_size = 32,
   parameter int unsigned bs                    = 16,
   parameter int unsigned SETTLE_CYC            = 2
) (
   input logic               clk,
   input logic               rst,
   esm_issue_buffer_if.slave bus
);
   localparam int unsigned IdxW = $clog2(bs);
   localparam int unsigned OccW = IdxW + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;

   logic [Instruction_word_size-1:0] mem_q [bs];
   logic [0:bs-1]                    valid_q, valid_d;
   logic [OccW-1:0]                  occ_q, occ_d;
   logic [2:0]                       cnt_q, cnt_d;
   logic [1:0]                       state_q, state_d;
   logic [IdxW-1:0]                  issue_slot_q, issue_slot_d;
   logic                             issue_valid_q, issue_valid_d;
   logic [Instruction_word_size-1:0] issue_instr_q, issue_instr_d;
   logic                             proceed_q;
   logic [Instruction_word_size-1:0] instr_q;
   logic                             regwrite_q, alusrc_q;
   logic [IdxW-1:0]                  bidx_q;

   logic            in_ready;
   logic            accept, retire, sel_hit;
   logic [IdxW-1:0] free_idx;

   // Gated by reset so every output reads 0 while reset is held.
   assign in_ready = rst & ~(&valid_q);
   assign accept   = bus.in_valid & in_ready;
   assign retire   = issue_valid_q & bus.issue_ready;
   assign sel_hit  = bus.sel_valid & valid_q[bus.sel_index];

   always_comb begin
      free_idx = '0;
      for (int i = int'(bs) - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IdxW'(i);
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (accept) valid_d[free_idx] = 1'b1;
      if (retire) valid_d[issue_slot_q] = 1'b0;
   end

   always_comb begin
      occ_d = occ_q;
      if (accept && !retire) occ_d = occ_q + 1'b1;
      else if (!accept && retire) occ_d = occ_q - 1'b1;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept || retire) cnt_d = 3'(SETTLE_CYC);
      else if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
   end

   always_comb begin
      state_d       = state_q;
      issue_slot_d  = issue_slot_q;
      issue_valid_d = issue_valid_q;
      issue_instr_d = issue_instr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            // A selection naming an empty slot is a core mismatch and is ignored.
            if (cnt_q == 3'd0 && sel_hit) begin
               issue_slot_d  = bus.sel_index;
               issue_instr_d = mem_q[bus.sel_index];
               issue_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (retire) begin
               issue_valid_d = 1'b0;
               state_d       = (valid_d == '0) ? S_IDLE : S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[free_idx] <= bus.in_instr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q       <= '0;
         occ_q         <= '0;
         cnt_q         <= '0;
         state_q       <= S_IDLE;
         issue_slot_q  <= '0;
         issue_valid_q <= 1'b0;
         issue_instr_q <= '0;
         proceed_q     <= 1'b0;
         instr_q       <= '0;
         regwrite_q    <= 1'b0;
         alusrc_q      <= 1'b0;
         bidx_q        <= '0;
      end else begin
         valid_q       <= valid_d;
         occ_q         <= occ_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         issue_slot_q  <= issue_slot_d;
         issue_valid_q <= issue_valid_d;
         issue_instr_q <= issue_instr_d;
         proceed_q     <= retire;
         if (accept) begin
            instr_q    <= bus.in_instr;
            regwrite_q <= bus.in_regwrite;
            alusrc_q   <= bus.in_alusrc;
            bidx_q     <= free_idx;
         end
      end
   end

`ifdef ESM_ISSUE_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (state_q == S_HOLD && !bus.issue_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_q;
`endif

   assign bus.in_ready          = in_ready;
   assign bus.Instr_out         = instr_q;
   assign bus.RegWrite_out      = regwrite_q;
   assign bus.ALUSrc_out        = alusrc_q;
   assign bus.buffer_index_out  = bidx_q;
   assign bus.valid_entries_out = valid_q;
   assign bus.proceed_out       = proceed_q;
   assign bus.issue_valid       = issue_valid_q;
   assign bus.issue_instr       = issue_instr_q;
   assign bus.occupancy         = occ_q;
endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer (bs=16, SETTLE_CYC=2).
module tb_esm_issue_buffer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [0:15] exp_map;

   always #5 clk = ~clk;

   esm_issue_buffer_if #(.Instruction_word_size(32), .bs(16)) bus ();

   esm_issue_buffer #(
      .Instruction_word_size(32),
      .bs                   (16),
      .SETTLE_CYC           (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_issue(input string tag);
      int n = 0;
      while (bus.issue_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_eq(tag, 64'(bus.issue_valid), 64'd1);
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_instr    = '0;
      bus.in_regwrite = 1'b0;
      bus.in_alusrc   = 1'b0;
      bus.sel_index   = '0;
      bus.sel_valid   = 1'b0;
      bus.issue_ready = 1'b0;
      exp_map         = '0;

      #12;
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("rst_occ", 64'(bus.occupancy), 64'd0);
      check_eq("rst_map", 64'(bus.valid_entries_out), 64'(exp_map));
      check_eq("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      check_eq("rst_instr_out", 64'(bus.Instr_out), 64'd0);
      check_eq("rst_proceed", 64'(bus.proceed_out), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("idle_in_ready", 64'(bus.in_ready), 64'd1);

      // Single load then issue with downstream always ready.
      bus.in_valid    = 1'b1;
      bus.in_instr    = 32'h00A00093;
      bus.in_regwrite = 1'b1;
      bus.in_alusrc   = 1'b1;
      step();
      bus.in_valid    = 1'b0;
      bus.in_regwrite = 1'b0;
      bus.in_alusrc   = 1'b0;
      exp_map[0] = 1'b1;
      check_eq("t1_instr_out", 64'(bus.Instr_out), 64'h00A00093);
      check_eq("t1_regwrite", 64'(bus.RegWrite_out), 64'd1);
      check_eq("t1_alusrc", 64'(bus.ALUSrc_out), 64'd1);
      check_eq("t1_bidx", 64'(bus.buffer_index_out), 64'd0);
      check_eq("t1_map", 64'(bus.valid_entries_out), 64'(exp_map));
      check_eq("t1_occ", 64'(bus.occupancy), 64'd1);
      check_eq("t1_iv0", 64'(bus.issue_valid), 64'd0);
      bus.sel_valid   = 1'b1;
      bus.sel_index   = 4'd0;
      bus.issue_ready = 1'b1;
      step();
      check_eq("t1_settle1", 64'(bus.issue_valid), 64'd0);
      step();
      check_eq("t1_settle2", 64'(bus.issue_valid), 64'd0);
      step();
      check_eq("t1_issue_valid", 64'(bus.issue_valid), 64'd1);
      check_eq("t1_issue_instr", 64'(bus.issue_instr), 64'h00A00093);
      step();
      exp_map[0] = 1'b0;
      check_eq("t1_retire_iv", 64'(bus.issue_valid), 64'd0);
      check_eq("t1_proceed", 64'(bus.proceed_out), 64'd1);
      check_eq("t1_map_empty", 64'(bus.valid_entries_out), 64'(exp_map));
      check_eq("t1_occ0", 64'(bus.occupancy), 64'd0);
      bus.sel_valid = 1'b0;
      step();
      check_eq("t1_proceed_end", 64'(bus.proceed_out), 64'd0);
      repeat (4) step();
      check_eq("t1_idle_no_issue", 64'(bus.issue_valid), 64'd0);

      // Fill all 16 slots with downstream stalled.
      bus.issue_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 32'h1000 + 32'(i);
         step();
         exp_map[i] = 1'b1;
         check_eq($sformatf("fill_bidx%0d", i), 64'(bus.buffer_index_out), 64'(i));
      end
      bus.in_valid = 1'b0;
      check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("full_occ", 64'(bus.occupancy), 64'd16);
      check_eq("full_map", 64'(bus.valid_entries_out), 64'(exp_map));

      // Retire slot 5, refill lands in slot 5.
      bus.sel_index = 4'd5;
      bus.sel_valid = 1'b1;
      wait_issue("s5_issue");
      check_eq("s5_instr", 64'(bus.issue_instr), 64'h1005);
      bus.sel_valid   = 1'b0;
      bus.issue_ready = 1'b1;
      step();
      exp_map[5] = 1'b0;
      bus.issue_ready = 1'b0;
      check_eq("s5_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("s5_occ", 64'(bus.occupancy), 64'd15);
      check_eq("s5_proceed", 64'(bus.proceed_out), 64'd1);
      check_eq("s5_map", 64'(bus.valid_entries_out), 64'(exp_map));
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h0000BEEF;
      step();
      bus.in_valid = 1'b0;
      exp_map[5] = 1'b1;
      check_eq("refill_bidx", 64'(bus.buffer_index_out), 64'd5);
      check_eq("refill_instr", 64'(bus.Instr_out), 64'h0000BEEF);
      check_eq("refill_occ", 64'(bus.occupancy), 64'd16);
      check_eq("refill_in_ready", 64'(bus.in_ready), 64'd0);

      // Free slot 3 so a load can coincide with the next retire.
      bus.sel_index = 4'd3;
      bus.sel_valid = 1'b1;
      wait_issue("s3_issue");
      bus.sel_valid   = 1'b0;
      bus.issue_ready = 1'b1;
      step();
      bus.issue_ready = 1'b0;
      exp_map[3] = 1'b0;
      check_eq("s3_occ", 64'(bus.occupancy), 64'd15);

      // Hold slot 7 stalled for 20 cycles, then retire alongside a load.
      bus.sel_index = 4'd7;
      bus.sel_valid = 1'b1;
      wait_issue("s7_issue");
      check_eq("s7_instr", 64'(bus.issue_instr), 64'h1007);
      bus.sel_valid = 1'b0;
      repeat (20) step();
      check_eq("s7_held_iv", 64'(bus.issue_valid), 64'd1);
      check_eq("s7_held_instr", 64'(bus.issue_instr), 64'h1007);
`ifdef ESM_ISSUE_STALL_CNT_EN
      check_eq("stall_20", 64'(bus.stall_cnt), 64'd20);
`endif
      bus.issue_ready = 1'b1;
      bus.in_valid    = 1'b1;
      bus.in_instr    = 32'h00003333;
      step();
      bus.issue_ready = 1'b0;
      bus.in_valid    = 1'b0;
      exp_map[7] = 1'b0;
      exp_map[3] = 1'b1;
      check_eq("sim_occ", 64'(bus.occupancy), 64'd15);
      check_eq("sim_map", 64'(bus.valid_entries_out), 64'(exp_map));
      check_eq("sim_proceed", 64'(bus.proceed_out), 64'd1);
      check_eq("sim_bidx", 64'(bus.buffer_index_out), 64'd3);
      check_eq("sim_iv", 64'(bus.issue_valid), 64'd0);
      step();
      check_eq("sim_proceed_once", 64'(bus.proceed_out), 64'd0);

      // Core selects the empty slot 7: nothing issues.
      bus.sel_index = 4'd7;
      bus.sel_valid = 1'b1;
      repeat (10) step();
      check_eq("mis_no_issue", 64'(bus.issue_valid), 64'd0);
      check_eq("mis_occ", 64'(bus.occupancy), 64'd15);
      bus.sel_index = 4'd2;
      wait_issue("s2_issue");
      check_eq("s2_instr", 64'(bus.issue_instr), 64'h1002);
      bus.sel_valid = 1'b0;

      // Asynchronous reset while holding slot 2.
`ifdef ESM_ISSUE_STALL_CNT_EN
      check_eq("stall_pre_rst", 64'(bus.stall_cnt), 64'd20);
`endif
      #2;
      rst = 1'b0;
      #1;
      exp_map = '0;
      check_eq("mrst_iv", 64'(bus.issue_valid), 64'd0);
      check_eq("mrst_issue_instr", 64'(bus.issue_instr), 64'd0);
      check_eq("mrst_occ", 64'(bus.occupancy), 64'd0);
      check_eq("mrst_map", 64'(bus.valid_entries_out), 64'(exp_map));
      check_eq("mrst_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("mrst_instr_out", 64'(bus.Instr_out), 64'd0);
      check_eq("mrst_bidx", 64'(bus.buffer_index_out), 64'd0);
      check_eq("mrst_proceed", 64'(bus.proceed_out), 64'd0);
`ifdef ESM_ISSUE_STALL_CNT_EN
      check_eq("stall_post_rst", 64'(bus.stall_cnt), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      bus.issue_ready = 1'b1;
      repeat (3) step();
      check_eq("post_rst_proceed", 64'(bus.proceed_out), 64'd0);
      check_eq("post_rst_iv", 64'(bus.issue_valid), 64'd0);
      check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("post_rst_occ", 64'(bus.occupancy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/esm_issue_buffer.md
Name: esm_issue_buffer

Overview:
- Instruction-side partner of the ESM core.
- Accepts fetched instructions into a bs-entry slot buffer and drives the core's load interface: instruction word, RegWrite, ALUSrc, buffer index and valid-entry bitmap.
- Consumes the core's selection result (next buffer index, valid count). Issues the selected independent instruction downstream over a valid/ready handshake, then pulses proceed back to the core.

Parameters:
- Instruction_word_size, 32, instruction width in bits.
- bs, 16, buffer slots; power of 2, at least 4.
- SETTLE_CYC, 2, cycles the core needs after any load or retire before its selection is trusted; 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch instruction valid.
- in_instr  in  Instruction_word_size  fetched instruction.
- in_regwrite  in  1  instruction writes a register.
- in_alusrc  in  1  instruction uses an immediate operand.
- in_ready  out  1  buffer can accept an instruction.
- Instr_out  out  Instruction_word_size  instruction presented to core.
- RegWrite_out  out  1  RegWrite presented to core.
- ALUSrc_out  out  1  ALUSrc presented to core.
- buffer_index_out  out  $clog2(bs)  slot being loaded into core.
- valid_entries_out  out  bs (index 0:bs-1)  occupied-slot bitmap.
- proceed_out  out  1  one-cycle retire pulse to core.
- sel_index  in  $clog2(bs)  core next_buffer_index.
- sel_valid  in  1  core valid_count; a selectable entry exists.
- issue_valid  out  1  downstream instruction valid.
- issue_instr  out  Instruction_word_size  downstream instruction.
- issue_ready  in  1  downstream accepts.
- occupancy  out  $clog2(bs)+1  number of occupied slots.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, bitmap 0, FSM=S_IDLE, settle counter 0. Slot storage is not reset.
- Load:
  - in_ready = bitmap not all ones. Loading is independent of FSM state.
  - Accept when in_valid & in_ready. Target slot = lowest-index clear bit.
  - Next edge: slot written, bitmap bit set, occupancy+1.
  - Instr_out/RegWrite_out/ALUSrc_out/buffer_index_out are registered copies of the accepted instruction. They update 1 cycle after accept and hold between loads.
  - Settle counter reloads to SETTLE_CYC.
- Settle counter decrements to 0 each cycle it is not reloaded.
- FSM:
  - S_IDLE: bitmap empty. First accept -> S_SETTLE.
  - S_SETTLE: wait for counter==0.
    - If sel_valid & bitmap[sel_index]: latch sel_index as the issue slot; issue_instr=slot contents; issue_valid=1 next cycle -> S_HOLD.
    - If sel_valid=0 or bitmap[sel_index]=0: stay in S_SETTLE. This is a core mismatch; the entry is not issued.
  - S_HOLD: issue_valid and issue_instr held stable until issue_ready. On issue_valid & issue_ready:
    - clear the issue slot's bit; occupancy-1; proceed_out=1 for exactly the next cycle; reload counter; issue_valid=0.
    - -> S_IDLE if the resulting bitmap is empty, else S_SETTLE.
- Simultaneous accept and retire in one cycle: both take effect; occupancy unchanged; counter reloads once.
  - A slot freed on this edge can be targeted from the next cycle, not the same one.
- Full (occupancy==bs): in_ready=0. Issue continues; one retire reopens in_ready the following cycle.
- Loads arriving during S_HOLD reload the counter but never change the held issue slot.
- issue_valid never rises while rst=0. Mid-operation reset discards all entries with no proceed pulse.

Optional Feature:
- Macro ESM_ISSUE_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], a saturating count of cycles in S_HOLD with issue_ready=0.
  - Reset to 0; cleared only by reset; sticks at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then one accept of instr 32'h00A00093 -> next cycle Instr_out=32'h00A00093, buffer_index_out=0, valid_entries_out bit0=1, occupancy=1; issue_valid stays 0 for SETTLE_CYC cycles.
- Slot 0 loaded, core drives sel_valid=1, sel_index=0, issue_ready=1 -> issue_valid high 1 cycle after settle; proceed_out single-cycle pulse; bitmap 0; FSM returns to S_IDLE.
- 16 back-to-back accepts with issue_ready=0 -> slots 0..15 filled in order; in_ready=0 after the 16th; occupancy=16. Retire slot 5 -> in_ready=1 next cycle; next accept lands in slot 5.
- In S_HOLD with issue_ready low, an accept arrives the same cycle issue_ready rises -> occupancy unchanged; retired slot cleared; new slot set; exactly one proceed pulse.
- sel_valid=1 with sel_index pointing at an empty slot -> no issue; FSM stays in S_SETTLE.
- Assert rst low mid-S_HOLD -> all outputs 0 immediately. With ESM_ISSUE_STALL_CNT_EN, after 20 stalled cycles stall_cnt=20 before reset and 0 after.
